// File: rtl/calendar_counter_if.sv
// Day/month/year calendar bus: load/tick requests in, binary date plus decoded
// month and length flags out.
interface calendar_counter_if #(
   parameter int YEAR_W = 12
);
   logic              tick;
   logic              load;
   logic [4:0]        load_day;
   logic [3:0]        load_month;
   logic [YEAR_W-1:0] load_year;
   logic [4:0]        day;
   logic [3:0]        month;
   logic [YEAR_W-1:0] year;
   logic [11:0]       month_oh;
   logic              len31;
   logic              len30;
   logic              len_feb;
   logic              leap;
   logic              month_end;
   logic              year_wrap;
   logic              load_err;

   modport master (
      output tick, load, load_day, load_month, load_year,
      input  day, month, year, month_oh, len31, len30, len_feb, leap,
             month_end, year_wrap, load_err
   );

   modport slave (
      input  tick, load, load_day, load_month, load_year,
      output day, month, year, month_oh, len31, len30, len_feb, leap,
             month_end, year_wrap, load_err
   );
endinterface

// File: rtl/calendar_counter.sv
// Calendar counter advanced by a one-day tick; Gregorian leap handling,
// validated date load and month/year rollover with a year-wrap pulse.
module calendar_counter #(
   parameter int YEAR_W     = 12,
   parameter int RESET_YEAR = 2000,
   parameter bit LEAP_EN    = 1'b1
) (
   input  logic               clk,
   input  logic               rst_n,
   calendar_counter_if.slave  bus
);
   logic [4:0]        day_q, day_d;
   logic [3:0]        month_q, month_d;
   logic [YEAR_W-1:0] year_q, year_d;
   logic              year_wrap_q, year_wrap_d;
   logic              load_err_q, load_err_d;
   logic              cur_leap;
   logic [4:0]        cur_len;
   logic              load_ok;

   function automatic logic is_leap(input logic [YEAR_W-1:0] y);
      logic [31:0] yy;
      yy = 32'(y);
      if (!LEAP_EN) return 1'b0;
      return ((yy % 32'd4) == 32'd0) &&
             (((yy % 32'd100) != 32'd0) || ((yy % 32'd400) == 32'd0));
   endfunction

   function automatic logic [4:0] month_len(input logic [3:0] m, input logic lp);
      case (m)
         4'd2:                     return lp ? 5'd29 : 5'd28;
         4'd4, 4'd6, 4'd9, 4'd11:  return 5'd30;
         default:                  return 5'd31;
      endcase
   endfunction

   assign cur_leap = is_leap(year_q);
   assign cur_len  = month_len(month_q, cur_leap);

   assign load_ok = (bus.load_month >= 4'd1) && (bus.load_month <= 4'd12) &&
                    (bus.load_day != 5'd0) &&
                    (bus.load_day <= month_len(bus.load_month, is_leap(bus.load_year)));

   always_comb begin
      day_d       = day_q;
      month_d     = month_q;
      year_d      = year_q;
      year_wrap_d = 1'b0;
      load_err_d  = 1'b0;
      if (bus.load) begin
         // a tick arriving with any load is dropped, even a rejected one
         if (load_ok) begin
            day_d   = bus.load_day;
            month_d = bus.load_month;
            year_d  = bus.load_year;
         end else begin
            load_err_d = 1'b1;
         end
      end else if (bus.tick) begin
         if (day_q != cur_len) begin
            day_d = day_q + 5'd1;
         end else begin
            day_d = 5'd1;
            if (month_q != 4'd12) begin
               month_d = month_q + 4'd1;
            end else begin
               month_d     = 4'd1;
               year_d      = year_q + 1'b1;
               year_wrap_d = (year_q == '1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         day_q       <= 5'd1;
         month_q     <= 4'd1;
         year_q      <= YEAR_W'(RESET_YEAR);
         year_wrap_q <= 1'b0;
         load_err_q  <= 1'b0;
      end else begin
         day_q       <= day_d;
         month_q     <= month_d;
         year_q      <= year_d;
         year_wrap_q <= year_wrap_d;
         load_err_q  <= load_err_d;
      end
   end

   always_comb begin
      bus.month_oh = '0;
      for (int k = 0; k < 12; k++) bus.month_oh[k] = (month_q == 4'(k + 1));
   end

   assign bus.day       = day_q;
   assign bus.month     = month_q;
   assign bus.year      = year_q;
   assign bus.len_feb   = (month_q == 4'd2);
   assign bus.len30     = (month_q == 4'd4) || (month_q == 4'd6) ||
                          (month_q == 4'd9) || (month_q == 4'd11);
   assign bus.len31     = !(bus.len_feb || bus.len30);
   assign bus.leap      = cur_leap;
   assign bus.month_end = (day_q == cur_len);
   assign bus.year_wrap = year_wrap_q;
   assign bus.load_err  = load_err_q;
endmodule

// File: tb/tb_calendar_counter.sv
// Self-checking bench for calendar_counter: vector table through a scoreboard
// queue, plus reset, long-count and LEAP_EN=0 sequences.
module tb_calendar_counter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   calendar_counter_if #(.YEAR_W(12)) cif ();
   calendar_counter_if #(.YEAR_W(12)) nif ();

   calendar_counter #(.YEAR_W(12), .RESET_YEAR(2000), .LEAP_EN(1'b1)) u_dut (
      .clk(clk), .rst_n(rst_n), .bus(cif.slave));
   calendar_counter #(.YEAR_W(12), .RESET_YEAR(2000), .LEAP_EN(1'b0)) u_noleap (
      .clk(clk), .rst_n(rst_n), .bus(nif.slave));

   typedef struct {
      logic        ld;
      logic        tk;
      int          ld_d, ld_m, ld_y;
      int          e_d, e_m, e_y;
      logic        e_wrap, e_err;
   } vec_t;

   typedef struct {
      int   d, m, y;
      logic wrap, err;
      logic leap_en;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int total = 0, passed = 0;

   function automatic vec_t mk(logic ld, logic tk, int ldd, int ldm, int ldy,
                               int ed, int em, int ey, logic w, logic er);
      vec_t v;
      v.ld = ld; v.tk = tk; v.ld_d = ldd; v.ld_m = ldm; v.ld_y = ldy;
      v.e_d = ed; v.e_m = em; v.e_y = ey; v.e_wrap = w; v.e_err = er;
      return v;
   endfunction

   function automatic logic m_leap(int y, logic en);
      if (!en) return 1'b0;
      return ((y % 4) == 0) && (((y % 100) != 0) || ((y % 400) == 0));
   endfunction

   function automatic int m_len(int m, int y, logic en);
      int tbl[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
      if (m == 2) return m_leap(y, en) ? 29 : 28;
      return tbl[m-1];
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic chk_dut(string tag, exp_t e);
      int ml;
      ml = m_len(e.m, e.y, e.leap_en);
      if (e.leap_en) begin
         chk({tag, " day"},   32'(cif.day),   32'(e.d));
         chk({tag, " month"}, 32'(cif.month), 32'(e.m));
         chk({tag, " year"},  32'(cif.year),  32'(e.y));
         chk({tag, " wrap"},  32'(cif.year_wrap), 32'(e.wrap));
         chk({tag, " err"},   32'(cif.load_err),  32'(e.err));
         chk({tag, " oh"},    32'(cif.month_oh),  32'(1) << (e.m - 1));
         chk({tag, " len"},   {29'd0, cif.len31, cif.len30, cif.len_feb},
             (e.m == 2) ? 32'd1 : (ml == 30) ? 32'd2 : 32'd4);
         chk({tag, " leap"},  32'(cif.leap), 32'(m_leap(e.y, 1'b1)));
         chk({tag, " mend"},  32'(cif.month_end), 32'(e.d == ml));
      end else begin
         chk({tag, " nl day"},   32'(nif.day),   32'(e.d));
         chk({tag, " nl month"}, 32'(nif.month), 32'(e.m));
         chk({tag, " nl year"},  32'(nif.year),  32'(e.y));
         chk({tag, " nl err"},   32'(nif.load_err), 32'(e.err));
         chk({tag, " nl leap"},  32'(nif.leap), 32'd0);
         chk({tag, " nl mend"},  32'(nif.month_end), 32'(e.d == ml));
      end
   endtask

   // Drive one cycle on the main DUT, push the expected result, compare after the edge
   task automatic step(vec_t v, string tag);
      exp_t e, got;
      @(negedge clk);
      cif.load = v.ld; cif.tick = v.tk;
      cif.load_day = 5'(v.ld_d); cif.load_month = 4'(v.ld_m); cif.load_year = 12'(v.ld_y);
      e.d = v.e_d; e.m = v.e_m; e.y = v.e_y; e.wrap = v.e_wrap; e.err = v.e_err;
      e.leap_en = 1'b1;
      sb.push_back(e);
      @(posedge clk); #1;
      cif.load = 1'b0; cif.tick = 1'b0;
      if (sb.size() == 0) begin
         total++; $display("FAIL %s: scoreboard empty", tag);
      end else begin
         got = sb.pop_front();
         chk_dut(tag, got);
      end
   endtask

   task automatic step_nl(logic ld, logic tk, int dd, int mm, int yy,
                          int ed, int em, int ey, logic er, string tag);
      exp_t e;
      @(negedge clk);
      nif.load = ld; nif.tick = tk;
      nif.load_day = 5'(dd); nif.load_month = 4'(mm); nif.load_year = 12'(yy);
      e.d = ed; e.m = em; e.y = ey; e.wrap = 1'b0; e.err = er; e.leap_en = 1'b0;
      sb.push_back(e);
      @(posedge clk); #1;
      nif.load = 1'b0; nif.tick = 1'b0;
      chk_dut(tag, sb.pop_front());
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      exp_t r;
      cif.load = 0; cif.tick = 0; cif.load_day = 0; cif.load_month = 0; cif.load_year = 0;
      nif.load = 0; nif.tick = 0; nif.load_day = 0; nif.load_month = 0; nif.load_year = 0;

      r.d = 1; r.m = 1; r.y = 2000; r.wrap = 0; r.err = 0; r.leap_en = 1'b1;
      repeat (3) @(posedge clk);
      #1 chk_dut("reset", r);
      @(negedge clk) rst_n = 1'b1;

      vecs.push_back(mk(1,0,31, 1,2023, 31, 1,2023,0,0));
      vecs.push_back(mk(0,1, 0, 0,   0,  1, 2,2023,0,0));
      foreach (vecs[i]) step(vecs[i], $sformatf("v%0d", i));
      for (int d = 2; d <= 28; d++) step(mk(0,1,0,0,0, d,2,2023,0,0), "feb23");
      vecs.delete();
      vecs.push_back(mk(0,1, 0, 0,   0,  1, 3,2023,0,0));
      vecs.push_back(mk(1,0,28, 2,2024, 28, 2,2024,0,0));
      vecs.push_back(mk(0,1, 0, 0,   0, 29, 2,2024,0,0));
      vecs.push_back(mk(0,1, 0, 0,   0,  1, 3,2024,0,0));
      vecs.push_back(mk(1,0,28, 2,1900, 28, 2,1900,0,0));
      vecs.push_back(mk(0,1, 0, 0,   0,  1, 3,1900,0,0));
      vecs.push_back(mk(1,0,28, 2,2000, 28, 2,2000,0,0));
      vecs.push_back(mk(0,1, 0, 0,   0, 29, 2,2000,0,0));
      vecs.push_back(mk(1,0,30, 4,2023, 30, 4,2023,0,0));
      vecs.push_back(mk(0,1, 0, 0,   0,  1, 5,2023,0,0));
      vecs.push_back(mk(1,0,31,12,4095, 31,12,4095,0,0));
      vecs.push_back(mk(0,1, 0, 0,   0,  1, 1,   0,1,0));
      vecs.push_back(mk(0,0, 0, 0,   0,  1, 1,   0,0,0));
      vecs.push_back(mk(1,0,31,12,2023, 31,12,2023,0,0));
      vecs.push_back(mk(0,1, 0, 0,   0,  1, 1,2024,0,0));
      vecs.push_back(mk(1,0,31, 4,2023,  1, 1,2024,0,1));
      vecs.push_back(mk(0,0, 0, 0,   0,  1, 1,2024,0,0));
      vecs.push_back(mk(1,0,29, 2,2023,  1, 1,2024,0,1));
      vecs.push_back(mk(1,0, 1, 0,2023,  1, 1,2024,0,1));
      vecs.push_back(mk(1,0, 1,13,2023,  1, 1,2024,0,1));
      vecs.push_back(mk(1,0, 0, 5,2023,  1, 1,2024,0,1));
      vecs.push_back(mk(0,0, 0, 0,   0,  1, 1,2024,0,0));
      vecs.push_back(mk(1,0,29, 2,2024, 29, 2,2024,0,0));
      vecs.push_back(mk(1,1,15, 6,2010, 15, 6,2010,0,0));
      vecs.push_back(mk(1,1,31, 6,2010, 15, 6,2010,0,1));
      vecs.push_back(mk(0,1, 0, 0,   0, 16, 6,2010,0,0));
      foreach (vecs[i]) step(vecs[i], $sformatf("t%0d", i));

      step_nl(1, 0, 28, 2, 2024, 28, 2, 2024, 0, "nl load");
      step_nl(0, 1, 0, 0, 0, 1, 3, 2024, 0, "nl tick");
      step_nl(1, 0, 29, 2, 2024, 1, 3, 2024, 1, "nl rej29");

      // asynchronous reset in the middle of a tick stream
      @(negedge clk); cif.tick = 1'b1;
      @(posedge clk); #3 rst_n = 1'b0;
      #1 chk_dut("async rst", r);
      @(posedge clk); #1 chk_dut("rst held", r);
      @(negedge clk); rst_n = 1'b1;
      cif.tick = 1'b0;
      step(mk(0,1,0,0,0, 2,1,2000,0,0), "first tick");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
